// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR definitions for the PRBS generator and checker
package lfsr_pkg;

  typedef enum logic [1:0] {FILL, VERIFY, LOCKED} chk_state_t;

  localparam int          LFSR_WIDTH = 32;
  localparam logic [31:0] LFSR_TAP   = 32'h80000032;
  localparam int          FB_MAX_W   = 64;

  // Single feedback definition used by both ends of the link; callers zero-extend to FB_MAX_W.
  function automatic logic lfsr_fb(input logic [FB_MAX_W-1:0] state,
                                   input logic [FB_MAX_W-1:0] tap);
    return ^(state & tap);
  endfunction

endpackage

// File: rtl/lfsr_err_window.sv
// rtl/lfsr_err_window.sv - per-window error counter that strobes when the loss-of-lock threshold is hit
module lfsr_err_window #(
  parameter int WIN_LEN    = 256,
  parameter int ERR_THRESH = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic beat,
  input  logic err,
  input  logic restart,
  output logic thresh_hit
);

  localparam int BW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int EW = $clog2(ERR_THRESH + 1);

  logic [BW-1:0] win_beat;
  logic [EW-1:0] win_err;
  logic [EW-1:0] err_next;
  logic          wrap;

  assign wrap = (win_beat == BW'(WIN_LEN - 1));

  // The wrap beat opens the new window, so its own error is counted there.
  always_comb begin
    err_next = wrap ? '0 : win_err;
    if (err) err_next = err_next + 1'b1;
  end

  assign thresh_hit = beat && err && (err_next == EW'(ERR_THRESH));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_beat <= '0;
      win_err  <= '0;
    end else if (restart) begin
      win_beat <= '0;
      win_err  <= '0;
    end else if (beat) begin
      win_beat <= wrap ? '0 : win_beat + 1'b1;
      win_err  <= err_next;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising PRBS checker with lock tracking and error counting
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int                 WIDTH      = LFSR_WIDTH,
  parameter logic [WIDTH-1:0]   TAP        = LFSR_TAP,
  parameter int                 LOCK_CNT   = 64,
  parameter int                 WIN_LEN    = 256,
  parameter int                 ERR_THRESH = 8,
  parameter int                 CNT_W      = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             rx_valid,
  input  logic             rx_bit,
  input  logic             clear,
  output logic             locked,
  output logic             bit_err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic             lock_lost
);

  localparam int FW = $clog2(WIDTH);
  localparam int MW = $clog2(LOCK_CNT + 1);

  chk_state_t       state, state_nx;
  logic [WIDTH-1:0] win, win_nx, shifted;
  logic [FW-1:0]    fill_cnt, fill_nx;
  logic [MW-1:0]    match_cnt, match_nx;
  logic             pred, mismatch, lk_beat, thresh_hit;

  assign pred     = lfsr_fb(FB_MAX_W'(win), FB_MAX_W'(TAP));
  assign shifted  = {win[WIDTH-2:0], rx_bit};
  assign mismatch = (rx_bit != pred);
  assign lk_beat  = rx_valid && (state == LOCKED);
  assign locked   = (state == LOCKED);

  lfsr_err_window #(
    .WIN_LEN    (WIN_LEN),
    .ERR_THRESH (ERR_THRESH)
  ) u_err_window (
    .clk        (clk),
    .n_rst      (n_rst),
    .beat       (lk_beat),
    .err        (mismatch),
    .restart    (thresh_hit),
    .thresh_hit (thresh_hit)
  );

  always_comb begin
    state_nx = state;
    win_nx   = win;
    fill_nx  = fill_cnt;
    match_nx = match_cnt;
    if (rx_valid) begin
      case (state)
        FILL: begin
          win_nx  = shifted;
          fill_nx = fill_cnt + 1'b1;
          if (fill_cnt == FW'(WIDTH - 1)) begin
            state_nx = VERIFY;
            fill_nx  = '0;
            match_nx = '0;
          end
        end
        VERIFY: begin
          win_nx = shifted;
          // An all-zero window is the LFSR lock-up state and can never predict a real stream.
          if (shifted == '0) begin
            state_nx = FILL;
            fill_nx  = '0;
            match_nx = '0;
          end else if (!mismatch) begin
            match_nx = match_cnt + 1'b1;
            if (match_cnt == MW'(LOCK_CNT - 1)) state_nx = LOCKED;
          end else begin
            match_nx = '0;
          end
        end
        LOCKED: begin
          if (thresh_hit) begin
            state_nx = FILL;
            fill_nx  = '0;
            match_nx = '0;
          end else begin
            win_nx = {win[WIDTH-2:0], pred};
          end
        end
        default: state_nx = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= FILL;
      win       <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      bit_err   <= 1'b0;
      lock_lost <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      state     <= state_nx;
      win       <= win_nx;
      fill_cnt  <= fill_nx;
      match_cnt <= match_nx;
      bit_err   <= lk_beat && mismatch;
      lock_lost <= thresh_hit;
      if (clear)
        err_count <= '0;
      else if (lk_beat && mismatch && (err_count != {CNT_W{1'b1}}))
        err_count <= err_count + 1'b1;
      if (clear)
        bit_count <= '0;
      else if (lk_beat && (bit_count != {CNT_W{1'b1}}))
        bit_count <= bit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - scoreboard bench for lfsr_checker against a history-based reference model
module tb_lfsr_checker;

  localparam int W          = 32;
  localparam int LOCK_CNT   = 64;
  localparam int WIN_LEN    = 256;
  localparam int ERR_THRESH = 8;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic        rx_bit = 1'b0;
  logic        clear = 1'b0;
  logic        locked, bit_err, lock_lost;
  logic [31:0] err_count, bit_count;

  lfsr_checker dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rx_valid  (rx_valid),
    .rx_bit    (rx_bit),
    .clear     (clear),
    .locked    (locked),
    .bit_err   (bit_err),
    .err_count (err_count),
    .bit_count (bit_count),
    .lock_lost (lock_lost)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        locked;
    logic        bit_err;
    logic        lock_lost;
    logic [31:0] errs;
    logic [31:0] bits;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Generator: the transmit-side LFSR, serial bit is the MSB.
  logic [31:0] tapv = 32'h80000032;
  logic [31:0] g    = 32'd34534;

  task automatic gen_next(output logic b);
    b = g[31];
    g = {g[30:0], ^(g & tapv)};
  endtask

  // Reference model: received-bit history (index 0 = newest), expressed as acquisition phases.
  int          mode;    // 0 collecting, 1 verifying, 2 locked
  int          fill_n, run_n, k;
  bit          hist[$];
  int          werr[int];
  logic [31:0] m_err, m_bits;

  function automatic logic model_pred();
    logic p = 1'b0;
    for (int i = 0; i < W; i++) if (tapv[i]) p ^= hist[i];
    return p;
  endfunction

  function automatic int hist_ones();
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(hist[i]);
    return n;
  endfunction

  task automatic model_reset();
    mode = 0; fill_n = 0; run_n = 0; k = 0;
    hist.delete();
    for (int i = 0; i < W; i++) hist.push_back(1'b0);
    werr.delete();
    m_err = 0; m_bits = 0;
  endtask

  task automatic hist_push(input logic b);
    hist.push_front(b);
    void'(hist.pop_back());
  endtask

  task automatic model_step(input logic v, input logic b, input logic clr);
    exp_t e;
    logic p;
    int   wid;
    e.bit_err = 1'b0;
    e.lock_lost = 1'b0;
    if (v) begin
      p = model_pred();
      if (mode == 0) begin
        hist_push(b);
        fill_n++;
        if (fill_n == W) begin mode = 1; run_n = 0; end
      end else if (mode == 1) begin
        hist_push(b);
        if (hist_ones() == 0) begin
          mode = 0; fill_n = 0;
        end else if (b == p) begin
          run_n++;
          if (run_n == LOCK_CNT) begin mode = 2; k = 0; werr.delete(); end
        end else begin
          run_n = 0;
        end
      end else begin
        if (m_bits != 32'hffffffff) m_bits++;
        wid = (k + 1) / WIN_LEN;
        k++;
        if (b != p) begin
          e.bit_err = 1'b1;
          if (m_err != 32'hffffffff) m_err++;
          werr[wid] = (werr.exists(wid) ? werr[wid] : 0) + 1;
        end
        if (b != p && werr[wid] == ERR_THRESH) begin
          e.lock_lost = 1'b1;
          mode = 0; fill_n = 0;
        end else begin
          hist_push(p);
        end
      end
    end
    if (clr) begin m_err = 0; m_bits = 0; end
    e.locked = (mode == 2);
    e.errs   = m_err;
    e.bits   = m_bits;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic b, input logic clr);
    rx_valid = v; rx_bit = b; clear = clr;
    @(posedge clk);
    #1;
    model_step(v, b, clr);
    @(negedge clk);
  endtask

  task automatic clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen_next(b);
      drive(1'b1, b, 1'b0);
    end
  endtask

  task automatic flipped(input logic clr);
    logic b;
    gen_next(b);
    drive(1'b1, ~b, clr);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0; clear = 1'b0;
    #3;
    n_rst = 1'b0;
    sb.delete();
    model_reset();
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_bit_err", 32'(bit_err), 32'd0);
    chk("rst_lock_lost", 32'(lock_lost), 32'd0);
    chk("rst_err_count", err_count, 32'd0);
    chk("rst_bit_count", bit_count, 32'd0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Monitor: every clocked cycle has an expected response waiting in the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (n_rst && sb.size() > 0) begin
      e = sb.pop_front();
      chk("locked", 32'(locked), 32'(e.locked));
      chk("bit_err", 32'(bit_err), 32'(e.bit_err));
      chk("lock_lost", 32'(lock_lost), 32'(e.lock_lost));
      chk("err_count", err_count, e.errs);
      chk("bit_count", bit_count, e.bits);
    end
  end

  initial begin
    logic v, b, f, c;
    model_reset();
    @(negedge clk);
    do_reset();

    clean(95);
    chk("no_lock_at_95", 32'(locked), 32'd0);
    clean(1);
    chk("lock_at_96", 32'(locked), 32'd1);
    clean(1000);
    chk("bits_after_1000", bit_count, 32'd1000);
    chk("clean_errs", err_count, 32'd0);

    flipped(1'b0);
    chk("single_bit_err", 32'(bit_err), 32'd1);
    clean(50);
    chk("single_err_count", err_count, 32'd1);
    chk("single_still_locked", 32'(locked), 32'd1);

    gen_next(b);
    drive(1'b1, b, 1'b1);
    for (int j = 0; j < ERR_THRESH; j++) begin
      flipped(1'b0);
      if (j == ERR_THRESH - 1) chk("lock_lost_on_8th", 32'(lock_lost), 32'd1);
      clean(9);
    end
    chk("unlocked_after_loss", 32'(locked), 32'd0);
    chk("errs_retained", err_count, 32'd8);
    clean(87);
    chk("relock_after_loss", 32'(locked), 32'd1);

    for (int i = 0; i < 500; i++) drive(1'b1, 1'b0, 1'b0);
    chk("stuck_never_locks", 32'(locked), 32'd0);

    do_reset();
    for (int i = 0; i < 96; i++) begin
      clean(1);
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    chk("gapped_lock", 32'(locked), 32'd1);

    flipped(1'b1);
    chk("clear_beats_err", err_count, 32'd0);
    chk("clear_err_pulse", 32'(bit_err), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 499) == 0);
      if (v) begin
        gen_next(b);
        drive(1'b1, b ^ f, c);
      end else begin
        drive(1'b0, 1'($urandom_range(0, 1)), c);
      end
    end

    clean(120);
    chk("locked_before_async_rst", 32'(locked), 32'd1);
    do_reset();
    clean(96);
    chk("relock_after_rst", 32'(locked), 32'd1);

    rx_valid = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
